// File: rtl/seven_seg_scanner.sv
// Six-digit common-anode seven-segment scanner with frame-aligned value updates
// and inter-digit blanking.
// Optional feature: define SCAN_BLANK_LEADING_ZERO_EN to keep the leftmost
// digit dark whenever its nibble is zero.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] digits_in,
    input  logic [5:0]  dp_in,
    input  logic        load,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        pending
);

    localparam int unsigned PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 30;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(5);

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] active;

    logic        slot_end_c;
    logic        wrap_c;
    logic [3:0]  nibble_c;
    logic        dp_bit_c;
    logic [6:0]  decode_c;
    logic [5:0]  an_nxt_c;
    logic [6:0]  seg_nxt_c;
    logic        dp_nxt_c;

    assign slot_end_c = (pre == PRE_LAST);
    assign wrap_c     = slot_end_c && (idx == IDX_LAST);

    // Prescaler and digit slot index.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
            idx <= '0;
        end else if (slot_end_c) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Shadow capture and frame-boundary transfer into the displayed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= {dp_in, digits_in};
            end
            if (wrap_c) begin
                pending <= 1'b0;
                if (load) begin
                    active <= {dp_in, digits_in};
                end else if (pending) begin
                    active <= shadow;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Select the nibble and decimal point of the digit currently being scanned.
    always_comb begin
        nibble_c = 4'h0;
        dp_bit_c = 1'b0;
        case (idx)
            3'd0: begin nibble_c = active[3:0];   dp_bit_c = active[24]; end
            3'd1: begin nibble_c = active[7:4];   dp_bit_c = active[25]; end
            3'd2: begin nibble_c = active[11:8];  dp_bit_c = active[26]; end
            3'd3: begin nibble_c = active[15:12]; dp_bit_c = active[27]; end
            3'd4: begin nibble_c = active[19:16]; dp_bit_c = active[28]; end
            3'd5: begin nibble_c = active[23:20]; dp_bit_c = active[29]; end
            default: begin nibble_c = 4'h0; dp_bit_c = 1'b0; end
        endcase
    end

    // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    always_comb begin
        decode_c = 7'b0111111;
        case (nibble_c)
            4'd0: decode_c = 7'b1000000;
            4'd1: decode_c = 7'b1111001;
            4'd2: decode_c = 7'b0100100;
            4'd3: decode_c = 7'b0110000;
            4'd4: decode_c = 7'b0011001;
            4'd5: decode_c = 7'b0010010;
            4'd6: decode_c = 7'b0000010;
            4'd7: decode_c = 7'b1111000;
            4'd8: decode_c = 7'b0000000;
            4'd9: decode_c = 7'b0010000;
            default: decode_c = 7'b0111111;
        endcase
    end

    // Next display drive: dark during the blanking window, else one anode lit.
    always_comb begin
        an_nxt_c  = 6'b111111;
        seg_nxt_c = 7'b1111111;
        dp_nxt_c  = 1'b1;
        if (pre >= BLANK_END) begin
`ifdef SCAN_BLANK_LEADING_ZERO_EN
            if (!((idx == IDX_LAST) && (active[23:20] == 4'h0))) begin
                an_nxt_c  = ~(6'(6'b000001 << idx));
                seg_nxt_c = decode_c;
                dp_nxt_c  = ~dp_bit_c;
            end
`else
            an_nxt_c  = ~(6'(6'b000001 << idx));
            seg_nxt_c = decode_c;
            dp_nxt_c  = ~dp_bit_c;
`endif
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= 6'b111111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt_c;
            seg        <= seg_nxt_c;
            dp         <= dp_nxt_c;
            frame_done <= wrap_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (REFRESH_DIV=8, BLANK_CYCLES=2).
// Honours SCAN_BLANK_LEADING_ZERO_EN when predicting the leftmost digit.
module tb_seven_seg_scanner;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 6 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] digits_in = '0;
    logic [5:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int failures = 0;

    logic [29:0] exp_q[$];

    seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .load(load), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {an,seg,dp} for output cycle k (1..FRAME) of a frame holding v.
    function automatic logic [13:0] pix(input logic [29:0] v, input int k);
        int p;
        int d;
        logic [3:0] nib;
        logic [5:0] a;
        p = (k - 1) % DIV;
        d = (k - 1) / DIV;
        if (p < BLANK) return {6'b111111, 7'b1111111, 1'b1};
        nib = 4'((v >> (d * 4)) & 30'hf);
`ifdef SCAN_BLANK_LEADING_ZERO_EN
        if (d == 5 && nib == 4'h0) return {6'b111111, 7'b1111111, 1'b1};
`endif
        a = ~(6'(1 << d));
        return {a, seg_of(nib), ~v[24 + d]};
    endfunction

    // Monitor: checks every display cycle of frames that have an expectation,
    // and the frame_done period.
    logic [29:0] cur = '0;
    bit          cur_valid = 0;
    bit          have_prev = 0;
    int          k = 0;
    int          since_fd = 0;

    always @(negedge clk) begin
        if (reset) begin
            cur_valid = 0;
            have_prev = 0;
            since_fd  = 0;
            k         = 0;
        end else begin
            since_fd++;
            if (cur_valid) begin
                k++;
                chk($sformatf("pix k=%0d", k), 32'({an, seg, dp}), 32'(pix(cur, k)));
            end
            if (frame_done === 1'b1) begin
                if (have_prev) chk("frame_period", 32'(since_fd), 32'(FRAME));
                have_prev = 1;
                since_fd  = 0;
                if (exp_q.size() > 0) begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1;
                    k         = 0;
                end else begin
                    cur_valid = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (frame_done !== 1'b1 && t < 4 * FRAME);
        if (frame_done !== 1'b1) chk("frame_done_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    initial begin
        // Reset held, then release and watch the first lit digit appear.
        step(3);
        chk("rst_an", 32'(an), 32'(6'h3f));
        chk("rst_seg", 32'(seg), 32'(7'h7f));
        chk("rst_dp", 32'(dp), 32'(1));
        chk("rst_fd", 32'(frame_done), 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        reset = 1'b0;
        exp_q.push_back(30'h0);
        step(1);
        chk("rel1_an", 32'(an), 32'(6'h3f));
        step(1);
        chk("rel2_an", 32'(an), 32'(6'h3f));
        step(1);
        chk("rel3_an", 32'(an), 32'(6'b111110));
        chk("rel3_seg", 32'(seg), 32'(7'b1000000));
        chk("rel3_dp", 32'(dp), 32'(1));

        // Load 123456 during slot 2; pending until the wrap.
        wait_fd();
        step(17);
        exp_q.push_back({6'b000000, 24'h123456});
        do_load(24'h123456, 6'b000000);
        chk("pend_set", 32'(pending), 32'(1));
        wait_fd();
        chk("pend_clr", 32'(pending), 32'(0));

        // Two loads in one frame: the last one wins.
        step(5);
        exp_q.push_back({6'b000000, 24'h999999});
        do_load(24'h111111, 6'b000000);
        step(13);
        do_load(24'h999999, 6'b000000);
        chk("pend_two", 32'(pending), 32'(1));
        wait_fd();

        // Load in the exact wrap cycle, with dashes and a decimal point.
        step(47);
        exp_q.push_back({6'b000001, 24'hA0000F});
        do_load(24'hA0000F, 6'b000001);
        chk("wrap_fd", 32'(frame_done), 32'(1));
        chk("wrap_pend", 32'(pending), 32'(0));
        wait_fd();

        // Leading zero on digit 5.
        step(10);
        exp_q.push_back({6'b000000, 24'h012345});
        do_load(24'h012345, 6'b000000);
        wait_fd();
        wait_fd();

        // Mid-frame reset discards the pending value.
        step(20);
        do_load(24'h777777, 6'b111111);
        chk("mid_pend", 32'(pending), 32'(1));
        reset = 1'b1;
        step(2);
        chk("mid_rst_pend", 32'(pending), 32'(0));
        chk("mid_rst_an", 32'(an), 32'(6'h3f));
        reset = 1'b0;
        exp_q.push_back(30'h0);
        wait_fd();
        chk("post_rst_pend", 32'(pending), 32'(0));
        wait_fd();
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
